sprite_loader: RTL

- Write-side counterpart of the sprite renderer: fills the 16x16 1-bpp sprite bitmap RAM that the renderer reads.
- Accepts a framed byte stream through a valid/ready handshake, from the UART/host bridge.
- Assembles one sprite into a shadow buffer and validates it.
- Commits the sprite to sprite RAM as 16 row writes, only inside vertical blanking, so the screen never shows a half-updated sprite.

---
 rtl/sprite_pkg.sv | 30 +++
 rtl/sprite_shadow_buf.sv | 41 ++++
 rtl/sprite_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared definitions for the sprite renderer and the sprite loader.
//   HEADER_DEFAULT : frame start byte used by the loader
//   SPRITE_W/H     : sprite bitmap geometry (16x16, 1 bpp)
//   Row word bit order: bit SPRITE_W-1 (bit 15) is the leftmost pixel,
//   bit 0 the rightmost. Both the loader and the renderer rely on this.
//   loader_state_e : sprite loader FSM encoding
// -----------------------------------------------------------------------------
package sprite_pkg;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam int         SPRITE_W       = 16;
    localparam int         SPRITE_H       = 16;
    localparam int         LEFTMOST_BIT   = SPRITE_W - 1;

    typedef logic [SPRITE_W-1:0]          row_t;
    typedef logic [$clog2(SPRITE_H)-1:0]  row_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INDEX,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CHECK,
        ST_WAIT_VBL,
        ST_COMMIT
    } loader_state_e;

endpackage

// File: rtl/sprite_shadow_buf.sv
// -----------------------------------------------------------------------------
// sprite_shadow_buf
// 16x16 register file holding one sprite while it is being assembled.
// Ports:
//   clk      : clock
//   wr_en    : byte-lane write strobe
//   wr_row   : row being written
//   wr_hi    : 1 = write bits [15:8], 0 = write bits [7:0]
//   wr_byte  : byte to write
//   rd_row   : row read address (combinational read)
//   rd_data  : contents of row rd_row
// -----------------------------------------------------------------------------
module sprite_shadow_buf
    import sprite_pkg::*;
(
    input  logic     clk,
    input  logic     wr_en,
    input  row_idx_t wr_row,
    input  logic     wr_hi,
    input  logic [7:0] wr_byte,
    input  row_idx_t rd_row,
    output row_t     rd_data
);

    row_t mem_q [SPRITE_H];

    // NOTE: storage array has no reset; every row is rewritten before any
    // commit can read it, so resetting it would only cost flop area.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_hi) begin
                mem_q[wr_row][15:8] <= wr_byte;
            end else begin
                mem_q[wr_row][7:0]  <= wr_byte;
            end
        end
    end

    assign rd_data = mem_q[rd_row];

endmodule

// File: rtl/sprite_loader.sv
// -----------------------------------------------------------------------------
// sprite_loader
// Receives a framed byte stream (HEADER, index, 32 row bytes[, checksum]),
// assembles the sprite in a shadow buffer and commits it to sprite RAM as
// 16 row writes starting on the next vblank_start pulse.
// Optional feature macro: SPRITE_LOADER_CHECKSUM_EN
//   defined   : frame ends with an XOR checksum byte, checked in ST_CHECK
//   undefined : no checksum byte, no XOR logic
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   in_data/valid/ready : byte stream handshake
//   vblank_start      : one-cycle pulse at start of vertical blanking
//   wr_en/sprite/row/data : sprite RAM row write port
//   busy              : FSM not idle
//   load_done         : pulse after a completed commit
//   load_err          : pulse on a rejected frame
// -----------------------------------------------------------------------------
module sprite_loader
    import sprite_pkg::*;
#(
    parameter int         NUM_SPRITES = 4,
    parameter int         IDX_W       = 2,
    parameter logic [7:0] HEADER      = HEADER_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             vblank_start,
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_sprite,
    output logic [3:0]       wr_row,
    output logic [15:0]      wr_data,
    output logic             busy,
    output logic             load_done,
    output logic             load_err
);

    loader_state_e    state_q, state_d;
    row_idx_t         row_q, row_d;
    logic [IDX_W-1:0] slot_q, slot_d;
    logic             in_ready_q, in_ready_d;
    logic             wr_en_q, wr_en_d;
    logic [IDX_W-1:0] wr_sprite_q, wr_sprite_d;
    row_idx_t         wr_row_q, wr_row_d;
    row_t             wr_data_q, wr_data_d;
    logic             busy_q, busy_d;
    logic             load_done_q, load_done_d;
    logic             load_err_q, load_err_d;

    logic     fire;
    logic     buf_we;
    logic     buf_hi;
    row_idx_t rd_row;
    row_t     rd_data;

    assign fire = in_valid && in_ready_q;

    // During COMMIT the registered outputs show row_q, so the buffer is read
    // one row ahead; row 0 is read while waiting to enter COMMIT.
    assign rd_row = (state_q == ST_COMMIT) ? row_q + 4'd1 : '0;

    sprite_shadow_buf u_shadow (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_row  (row_q),
        .wr_hi   (buf_hi),
        .wr_byte (in_data),
        .rd_row  (rd_row),
        .rd_data (rd_data)
    );

`ifdef SPRITE_LOADER_CHECKSUM_EN
    logic [7:0] xor_q, xor_d;

    always_comb begin
        xor_d = xor_q;
        if (state_q == ST_INDEX) begin
            xor_d = 8'h00;
        end else if (buf_we) begin
            xor_d = xor_q ^ in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) xor_q <= 8'h00;
        else     xor_q <= xor_d;
    end
`endif

    // NOTE: every signal gets a default at the top of the block so that no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        slot_d      = slot_q;
        buf_we      = 1'b0;
        buf_hi      = 1'b0;
        wr_en_d     = 1'b0;
        wr_sprite_d = wr_sprite_q;
        wr_row_d    = '0;
        wr_data_d   = '0;
        load_done_d = 1'b0;
        load_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fire && in_data == HEADER) state_d = ST_INDEX;
            end
            ST_INDEX: begin
                if (fire) begin
                    if (int'(in_data) < NUM_SPRITES) begin
                        slot_d  = in_data[IDX_W-1:0];
                        row_d   = '0;
                        state_d = ST_DATA_HI;
                    end else begin
                        load_err_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_DATA_HI: begin
                if (fire) begin
                    buf_we  = 1'b1;
                    buf_hi  = 1'b1;
                    state_d = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (fire) begin
                    buf_we = 1'b1;
                    if (row_q == 4'd15) begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_WAIT_VBL;
`endif
                    end else begin
                        row_d   = row_q + 4'd1;
                        state_d = ST_DATA_HI;
                    end
                end
            end
`ifdef SPRITE_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (fire) begin
                    if (in_data == xor_q) begin
                        state_d = ST_WAIT_VBL;
                    end else begin
                        load_err_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
`endif
            ST_WAIT_VBL: begin
                if (vblank_start) begin
                    state_d     = ST_COMMIT;
                    row_d       = '0;
                    wr_en_d     = 1'b1;
                    wr_sprite_d = slot_q;
                    wr_row_d    = '0;
                    wr_data_d   = rd_data;
                end
            end
            ST_COMMIT: begin
                if (row_q == 4'd15) begin
                    load_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    row_d     = row_q + 4'd1;
                    wr_en_d   = 1'b1;
                    wr_row_d  = row_q + 4'd1;
                    wr_data_d = rd_data;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered from the next state so they line up with it exactly.
        in_ready_d = !(state_d == ST_WAIT_VBL || state_d == ST_COMMIT);
        busy_d     = (state_d != ST_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            slot_q      <= '0;
            in_ready_q  <= 1'b1;
            wr_en_q     <= 1'b0;
            wr_sprite_q <= '0;
            wr_row_q    <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            slot_q      <= slot_d;
            in_ready_q  <= in_ready_d;
            wr_en_q     <= wr_en_d;
            wr_sprite_q <= wr_sprite_d;
            wr_row_q    <= wr_row_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign wr_en     = wr_en_q;
    assign wr_sprite = wr_sprite_q;
    assign wr_row    = wr_row_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule
